pll_clk_seq: RTL and testbench
==============================

Name: pll_clk_seq

Overview:
- Sits directly downstream of the Gowin PLL wrapper.
- Consumes the PLL `lock` output and drives the PLL per-output clock enables (`enclk0..3`) in a staggered power-up order.
- Releases the synchronous-domain system reset only after all requested clocks are running.
- On loss of lock it re-sequences from scratch. It runs on the PLL reference clock (50 MHz), which is unaffected by PLL state.

Parameters:
- NUM_CLK, 4: number of PLL clock enables sequenced; enable index 0 is enabled first.
- LOCK_STABLE_CYCLES, 1024: cycles the synchronized lock must stay high before the first enable step.
- EN_GAP_CYCLES, 16: cycles between successive enable steps.
- RST_HOLD_CYCLES, 64: cycles after the last enable step before `sys_resetn` releases.
- CNT_W, 16: shared counter width; must satisfy 2^CNT_W > max(LOCK_STABLE_CYCLES, EN_GAP_CYCLES, RST_HOLD_CYCLES).

Ports:
- clk, in, 1: reference clock; same net as PLL `clkin`.
- resetn, in, 1: asynchronous active-low reset.
- pll_lock, in, 1: PLL `lock`; asynchronous to `clk`.
- en_mask, in, NUM_CLK: per-clock request; 1 = enable this PLL output. Quasi-static.
- enclk, out, NUM_CLK: to PLL `enclk0..enclk(NUM_CLK-1)`.
- sys_resetn, out, 1: active-low system reset for downstream logic.
- ready, out, 1: high when in RUN.
- lock_lost_cnt, out, 8: saturating count of lock losses after the sequence started.
- state, out, 3: current FSM state, for debug.

Behaviour:
- Reset (resetn=0, asynchronous): all flops clear.
  - enclk=0, sys_resetn=0, ready=0, lock_lost_cnt=0, state=WAIT_LOCK(0).
  - Counter=0, step index=0, synchronizer flops=0.
- Lock synchronizer: 2-flop; lock_s lags pll_lock by 2 edges. Only lock_s is used internally.
- FSM encoding: WAIT_LOCK=0, STABLE=1, ENABLE=2, RST_HOLD=3, RUN=4. Other codes go to WAIT_LOCK next cycle.
- WAIT_LOCK:
  - Counter=0, idx=0.
  - lock_s=1 → STABLE, with counter=0.
- STABLE:
  - Counter increments each cycle.
  - When counter==LOCK_STABLE_CYCLES-1 → ENABLE, counter=0.
  - STABLE therefore lasts exactly LOCK_STABLE_CYCLES cycles.
- ENABLE:
  - Counter runs 0..EN_GAP_CYCLES-1.
  - At wrap: enclk[idx] <= en_mask[idx], idx increments, counter=0.
  - Masked-off outputs still consume a full gap, so timing is mask-independent.
  - The step for idx==NUM_CLK-1 also moves to RST_HOLD with counter=0.
  - Already-set enclk bits hold.
- RST_HOLD:
  - Counter increments.
  - When counter==RST_HOLD_CYCLES-1 → RUN; sys_resetn<=1 and ready<=1 on the same edge.
- RUN:
  - enclk <= en_mask each cycle, giving runtime gating with 1-cycle latency.
  - sys_resetn and ready stay high.
- Timing from the edge that first samples pll_lock=1 (edge 1):
  - STABLE is entered at edge 3.
  - enclk[i] rises at edge 3+LOCK_STABLE_CYCLES+(i+1)*EN_GAP_CYCLES.
  - ready and sys_resetn rise at edge 3+LOCK_STABLE_CYCLES+NUM_CLK*EN_GAP_CYCLES+RST_HOLD_CYCLES.
- Lock loss (lock_s=0) in STABLE, ENABLE, RST_HOLD or RUN:
  - Takes priority over all other transitions.
  - Next edge: enclk=0, sys_resetn=0, ready=0, counter=0, idx=0, state=WAIT_LOCK.
  - lock_lost_cnt increments (saturating at 255) only if loss occurs in ENABLE, RST_HOLD or RUN. Loss in STABLE is not counted.
- lock_lost_cnt clears only on resetn.
- Lock glitches shorter than one clk period may be missed; no filtering beyond STABLE.
- en_mask changes during ENABLE affect only steps not yet taken.

Test Plan (params LOCK_STABLE_CYCLES=8, EN_GAP_CYCLES=4, RST_HOLD_CYCLES=4, NUM_CLK=4):
- Nominal power-up: release resetn, en_mask=4'hF, pll_lock=1 from edge 1 → enclk[0..3] rise at edges 15/19/23/27; ready=sys_resetn=1 at edge 31; lock_lost_cnt=0.
- Masked outputs: en_mask=4'b1010 → enclk[1] rises at edge 19, enclk[3] at edge 27, enclk[0] and enclk[2] stay 0; ready still at edge 31.
- Lock chatter in STABLE: drop pll_lock for 3 cycles at edge 6 → FSM returns to WAIT_LOCK, lock_lost_cnt=0, full 8-cycle STABLE restarts after relock.
- Loss in RUN: in RUN, drop pll_lock → 3 edges after the drop, enclk=0, sys_resetn=0, ready=0, state=0, lock_lost_cnt=1; relock re-sequences with identical timing.
- Runtime gating and saturation: in RUN set en_mask 4'hF→4'h1 → enclk=4'h1 one edge later. Force 300 losses in RUN → lock_lost_cnt holds 255.
- Async reset mid-ENABLE: assert resetn low between clock edges → all outputs 0 immediately (no clock edge needed); state=0.

Source files
------------

// File: rtl/pll_clk_seq.sv
// Power-up sequencer for the PLL: waits for a stable lock, staggers the per-output
// clock enables, then releases the downstream system reset. Re-sequences on lock loss.
module pll_clk_seq #(
    parameter int unsigned NUM_CLK            = 4,
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned EN_GAP_CYCLES      = 16,
    parameter int unsigned RST_HOLD_CYCLES    = 64,
    parameter int unsigned CNT_W              = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               pll_lock,
    input  logic [NUM_CLK-1:0] en_mask,
    output logic [NUM_CLK-1:0] enclk,
    output logic               sys_resetn,
    output logic               ready,
    output logic [7:0]         lock_lost_cnt,
    output logic [2:0]         state
);

    localparam int unsigned IDX_W = (NUM_CLK > 1) ? $clog2(NUM_CLK) : 1;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        STABLE    = 3'd1,
        ENABLE    = 3'd2,
        RST_HOLD  = 3'd3,
        RUN       = 3'd4
    } state_e;

    logic               sync1_q;
    logic               lock_s_q;
    state_e             state_q,      state_d;
    logic [CNT_W-1:0]   cnt_q,        cnt_d;
    logic [IDX_W-1:0]   idx_q,        idx_d;
    logic [NUM_CLK-1:0] enclk_q,      enclk_d;
    logic               sys_resetn_q, sys_resetn_d;
    logic               ready_q,      ready_d;
    logic [7:0]         lost_q,       lost_d;
    logic               go_wait;
    logic               count_loss;

    // Next-state and registered-output logic; lock loss overrides every transition.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        enclk_d      = enclk_q;
        sys_resetn_d = sys_resetn_q;
        ready_d      = ready_q;
        lost_d       = lost_q;
        go_wait      = 1'b0;
        count_loss   = 1'b0;

        case (state_q)
            WAIT_LOCK: begin
                cnt_d = '0;
                idx_d = '0;
                if (lock_s_q) begin
                    state_d = STABLE;
                end
            end
            STABLE: begin
                if (!lock_s_q) begin
                    go_wait = 1'b1;
                end else if (cnt_q == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
                    state_d = ENABLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ENABLE: begin
                if (!lock_s_q) begin
                    go_wait    = 1'b1;
                    count_loss = 1'b1;
                end else if (cnt_q == CNT_W'(EN_GAP_CYCLES - 1)) begin
                    // Masked-off steps still spend a full gap so timing never depends on the mask.
                    enclk_d[idx_q] = en_mask[idx_q];
                    cnt_d          = '0;
                    idx_d          = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(NUM_CLK - 1)) begin
                        state_d = RST_HOLD;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RST_HOLD: begin
                if (!lock_s_q) begin
                    go_wait    = 1'b1;
                    count_loss = 1'b1;
                end else if (cnt_q == CNT_W'(RST_HOLD_CYCLES - 1)) begin
                    state_d      = RUN;
                    cnt_d        = '0;
                    sys_resetn_d = 1'b1;
                    ready_d      = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                if (!lock_s_q) begin
                    go_wait    = 1'b1;
                    count_loss = 1'b1;
                end else begin
                    enclk_d = en_mask;
                end
            end
            default: begin
                go_wait = 1'b1;
            end
        endcase

        if (go_wait) begin
            state_d      = WAIT_LOCK;
            cnt_d        = '0;
            idx_d        = '0;
            enclk_d      = '0;
            sys_resetn_d = 1'b0;
            ready_d      = 1'b0;
        end
        if (count_loss && (lost_q != 8'hFF)) begin
            lost_d = lost_q + 8'd1;
        end
    end

    // State registers plus the 2-flop lock synchronizer.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1_q      <= 1'b0;
            lock_s_q     <= 1'b0;
            state_q      <= WAIT_LOCK;
            cnt_q        <= '0;
            idx_q        <= '0;
            enclk_q      <= '0;
            sys_resetn_q <= 1'b0;
            ready_q      <= 1'b0;
            lost_q       <= 8'd0;
        end else begin
            sync1_q      <= pll_lock;
            lock_s_q     <= sync1_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            enclk_q      <= enclk_d;
            sys_resetn_q <= sys_resetn_d;
            ready_q      <= ready_d;
            lost_q       <= lost_d;
        end
    end

    assign enclk         = enclk_q;
    assign sys_resetn    = sys_resetn_q;
    assign ready         = ready_q;
    assign lock_lost_cnt = lost_q;
    assign state         = state_q;

endmodule

// File: tb/tb_pll_clk_seq.sv
// Directed bench for pll_clk_seq with short timing parameters (L=8, G=4, R=4, N=4):
// edge numbers below count from the first edge that samples pll_lock=1.
module tb_pll_clk_seq;

    logic       clk;
    logic       resetn;
    logic       pll_lock;
    logic [3:0] en_mask;
    logic [3:0] enclk;
    logic       sys_resetn;
    logic       ready;
    logic [7:0] lock_lost_cnt;
    logic [2:0] state;

    int n_checks;
    int n_fail;

    pll_clk_seq #(
        .NUM_CLK            (4),
        .LOCK_STABLE_CYCLES (8),
        .EN_GAP_CYCLES      (4),
        .RST_HOLD_CYCLES    (4),
        .CNT_W              (16)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .pll_lock      (pll_lock),
        .en_mask       (en_mask),
        .enclk         (enclk),
        .sys_resetn    (sys_resetn),
        .ready         (ready),
        .lock_lost_cnt (lock_lost_cnt),
        .state         (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hand-derived timeline: STABLE at 3, ENABLE at 11, enclk[i] at 15+4i, RST_HOLD at 27, RUN at 31.
    task automatic run_seq(input logic [3:0] mask, input int first_e);
        logic [3:0] exp_en;
        logic [2:0] exp_st;
        for (int e = first_e; e <= 31; e++) begin
            step();
            exp_en = 4'h0;
            for (int i = 0; i < 4; i++) begin
                if (e >= 15 + 4 * i) exp_en[i] = mask[i];
            end
            if (e < 3)       exp_st = 3'd0;
            else if (e < 11) exp_st = 3'd1;
            else if (e < 27) exp_st = 3'd2;
            else if (e < 31) exp_st = 3'd3;
            else             exp_st = 3'd4;
            check($sformatf("enclk@%0d", e), 32'(enclk), 32'(exp_en));
            check($sformatf("state@%0d", e), 32'(state), 32'(exp_st));
            check($sformatf("ready@%0d", e), 32'(ready), 32'(e >= 31));
            check($sformatf("sys_resetn@%0d", e), 32'(sys_resetn), 32'(e >= 31));
        end
    endtask

    // Drop lock long enough for the FSM to land in WAIT_LOCK, then re-raise it before the next edge.
    task automatic lose_lock();
        pll_lock = 1'b0;
        step();
        step();
        step();
        pll_lock = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        resetn   = 1'b0;
        pll_lock = 1'b0;
        en_mask  = 4'hF;

        #12;
        check("rst_enclk", 32'(enclk), 32'h0);
        check("rst_sys_resetn", 32'(sys_resetn), 32'h0);
        check("rst_ready", 32'(ready), 32'h0);
        check("rst_lost", 32'(lock_lost_cnt), 32'h0);
        check("rst_state", 32'(state), 32'h0);

        // Lock chatter in STABLE: lock low for edges 6..8, back high from edge 9.
        resetn   = 1'b1;
        pll_lock = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            step();
            check($sformatf("chat_state@%0d", e), 32'(state), (e < 3) ? 32'd0 : 32'd1);
        end
        pll_lock = 1'b0;
        step();
        check("chat_state@6", 32'(state), 32'd1);
        step();
        check("chat_state@7", 32'(state), 32'd1);
        step();
        check("chat_state@8", 32'(state), 32'd0);
        pll_lock = 1'b1;
        step();
        check("chat_state@9", 32'(state), 32'd0);
        step();
        check("chat_state@10", 32'(state), 32'd0);
        run_seq(4'hF, 3);
        check("chat_lost", 32'(lock_lost_cnt), 32'd0);

        // Loss in RUN: outputs drop on the third edge after the drop.
        pll_lock = 1'b0;
        step();
        check("loss_state_a", 32'(state), 32'd4);
        step();
        check("loss_state_a1", 32'(state), 32'd4);
        check("loss_enclk_a1", 32'(enclk), 32'hF);
        step();
        check("loss_enclk", 32'(enclk), 32'h0);
        check("loss_sys_resetn", 32'(sys_resetn), 32'h0);
        check("loss_ready", 32'(ready), 32'h0);
        check("loss_state", 32'(state), 32'd0);
        check("loss_lost", 32'(lock_lost_cnt), 32'd1);

        pll_lock = 1'b1;
        run_seq(4'hF, 1);
        check("relock_lost", 32'(lock_lost_cnt), 32'd1);

        // Runtime gating in RUN with one-edge latency.
        en_mask = 4'h1;
        check("gate_before", 32'(enclk), 32'hF);
        step();
        check("gate_after", 32'(enclk), 32'h1);
        en_mask = 4'hF;
        step();
        check("gate_restore", 32'(enclk), 32'hF);

        // Asynchronous reset between edges, then a masked sequence.
        #2;
        resetn = 1'b0;
        #1;
        check("ar1_enclk", 32'(enclk), 32'h0);
        check("ar1_ready", 32'(ready), 32'h0);
        check("ar1_lost", 32'(lock_lost_cnt), 32'h0);
        check("ar1_state", 32'(state), 32'h0);
        resetn  = 1'b1;
        en_mask = 4'b1010;
        run_seq(4'b1010, 1);

        // Saturation: 300 losses in RUN.
        for (int i = 0; i < 300; i++) begin
            lose_lock();
            if (i == 253) check("sat_254", 32'(lock_lost_cnt), 32'd254);
            repeat (31) step();
        end
        check("sat_lost", 32'(lock_lost_cnt), 32'd255);
        check("sat_ready", 32'(ready), 32'd1);

        // Async reset in the middle of ENABLE (edge 20: enclk[1] already set by mask 1010).
        lose_lock();
        check("sat_hold", 32'(lock_lost_cnt), 32'd255);
        repeat (20) step();
        check("mid_enclk", 32'(enclk), 32'h2);
        check("mid_state", 32'(state), 32'd2);
        #3;
        resetn = 1'b0;
        #1;
        check("ar2_enclk", 32'(enclk), 32'h0);
        check("ar2_sys_resetn", 32'(sys_resetn), 32'h0);
        check("ar2_ready", 32'(ready), 32'h0);
        check("ar2_lost", 32'(lock_lost_cnt), 32'h0);
        check("ar2_state", 32'(state), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
